// File: rtl/orb_pkg.sv
// Shared definitions for the orbit response collector: state encoding,
// default fill byte and a width helper that never returns zero.
package orb_pkg;

  localparam logic [7:0] FILL_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  // Index width for a field holding 0..value-1, at least one bit wide.
  function automatic int clog2_min1(input int value);
    int r;
    r = $clog2(value);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_resp_collector_chan_buf.sv
// One channel's response store: BYTES-deep byte array, write counter and a
// sticky overflow flag. Bytes never written in this cycle read back as FILL.
module uart_chan_buf
  import orb_pkg::*;
#(
  parameter int         BYTES = 4,
  parameter logic [7:0] FILL  = FILL_DEFAULT,
  localparam int        IDXW  = clog2_min1(BYTES),
  localparam int        CW    = $clog2(BYTES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  input  logic [IDXW-1:0] rd_idx,
  output logic [7:0]      rd_data,
  output logic [CW-1:0]   wcnt,
  output logic            ovf
);

  localparam logic [CW-1:0] FULL = CW'(BYTES);

  logic [7:0]    mem_q [BYTES];
  logic [7:0]    mem_d [BYTES];
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          ovf_q, ovf_d;

  // Append on strobe while room remains; a strobe into a full buffer only flags overflow.
  always_comb begin
    mem_d  = mem_q;
    wcnt_d = wcnt_q;
    ovf_d  = ovf_q;
    if (clr) begin
      wcnt_d = '0;
      ovf_d  = 1'b0;
    end else if (wr_en) begin
      if (wcnt_q < FULL) begin
        mem_d[wcnt_q[IDXW-1:0]] = wr_data;
        wcnt_d = wcnt_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Storage, counter and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      wcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      wcnt_q <= wcnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Read port: positions at or beyond the write count were never received.
  always_comb begin
    rd_data = FILL;
    if (CW'(rd_idx) < wcnt_q) rd_data = mem_q[rd_idx];
  end

  assign wcnt = wcnt_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/uart_resp_collector.sv
// N-channel LCB response collector: gathers BYTES bytes per enabled channel
// after i_start, then drains channels 0..N-1 as a single valid/ready stream.
// Stream handshake: a byte transfers on any clk edge where o_valid && i_ready;
// o_data/o_ch/o_idx/o_last hold steady while o_valid && !i_ready.
module uart_resp_collector
  import orb_pkg::*;
#(
  parameter int         N       = 5,
  parameter int         BYTES   = 4,
  parameter int         TIMEOUT = 4000,
  parameter logic [7:0] FILL    = FILL_DEFAULT,
  localparam int        CHW     = clog2_min1(N),
  localparam int        IDXW    = clog2_min1(BYTES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [N-1:0]    i_ch_en,
  input  logic [N-1:0]    i_rx_valid,
  input  logic [8*N-1:0]  i_rx_data,
  output logic [7:0]      o_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [CHW-1:0]  o_ch,
  output logic [IDXW-1:0] o_idx,
  output logic            o_last,
  output logic            o_busy,
  output logic [N-1:0]    o_err,
  output logic            o_done
);

  localparam int              CW       = $clog2(BYTES + 1);
  localparam int              TW       = clog2_min1(TIMEOUT);
  localparam logic [CW-1:0]   FULL     = CW'(BYTES);
  localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(BYTES - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    en_q, en_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [N-1:0]    tmo_err_q, tmo_err_d;
  logic [CHW-1:0]  nxt_ch_q, nxt_ch_d;
  logic [IDXW-1:0] nxt_idx_q, nxt_idx_d;
  logic [7:0]      o_data_q, o_data_d;
  logic [CHW-1:0]  o_ch_q, o_ch_d;
  logic [IDXW-1:0] o_idx_q, o_idx_d;
  logic            o_valid_q, o_valid_d;
  logic            o_last_q, o_last_d;
  logic            o_done_q, o_done_d;

  logic [N-1:0]    wr_en;
  logic [N-1:0]    ovf;
  logic [7:0]      rd_data [N];
  logic [CW-1:0]   wcnt [N];
  logic            all_complete, any_en, drain_load;
  logic [CHW-1:0]  first_en, hi_en, after_en;

  for (genvar k = 0; k < N; k++) begin : g_chan
    uart_chan_buf #(.BYTES(BYTES), .FILL(FILL)) u_buf (
      .clk     (clk),
      .rst_n   (rst),
      .clr     (i_start),
      .wr_en   (wr_en[k]),
      .wr_data (i_rx_data[8*k +: 8]),
      .rd_idx  (nxt_idx_q),
      .rd_data (rd_data[k]),
      .wcnt    (wcnt[k]),
      .ovf     (ovf[k])
    );
  end

  // Write qualification, completion test and enabled-channel search for the drain walk.
  always_comb begin
    wr_en        = '0;
    all_complete = 1'b1;
    any_en       = |en_q;
    first_en     = '0;
    hi_en        = '0;
    after_en     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      wr_en[k] = (state_q == COLLECT) && en_q[k] && i_rx_valid[k] && !i_start;
      if (en_q[k] && (wcnt[k] != FULL)) all_complete = 1'b0;
      if (en_q[k]) first_en = CHW'(k);
      if (en_q[k] && (k > int'(nxt_ch_q))) after_en = CHW'(k);
    end
    for (int k = 0; k < N; k++) begin
      if (en_q[k]) hi_en = CHW'(k);
    end
  end

  // FSM next state, timeout counter and drain output staging; i_start overrides all.
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    tcnt_d     = tcnt_q;
    tmo_err_d  = tmo_err_q;
    nxt_ch_d   = nxt_ch_q;
    nxt_idx_d  = nxt_idx_q;
    o_data_d   = o_data_q;
    o_ch_d     = o_ch_q;
    o_idx_d    = o_idx_q;
    o_valid_d  = o_valid_q;
    o_last_d   = o_last_q;
    o_done_d   = 1'b0;
    drain_load = 1'b0;
    case (state_q)
      IDLE: begin
      end
      COLLECT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (all_complete || (tcnt_q == T_LAST)) begin
          state_d   = DRAIN;
          nxt_ch_d  = first_en;
          nxt_idx_d = '0;
          // Completion takes precedence: errors only when genuinely short.
          if (!all_complete) begin
            for (int k = 0; k < N; k++) begin
              tmo_err_d[k] = en_q[k] && (wcnt[k] != FULL);
            end
          end
        end
      end
      DRAIN: begin
        if (!o_valid_q) begin
          // First drain cycle: stage the first byte, or finish at once if nothing is enabled.
          if (any_en) begin
            drain_load = 1'b1;
          end else begin
            state_d  = IDLE;
            o_done_d = 1'b1;
          end
        end else if (i_ready) begin
          if (o_last_q) begin
            state_d   = IDLE;
            o_valid_d = 1'b0;
            o_last_d  = 1'b0;
            o_done_d  = 1'b1;
          end else begin
            drain_load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (drain_load) begin
      o_data_d  = rd_data[nxt_ch_q];
      o_ch_d    = nxt_ch_q;
      o_idx_d   = nxt_idx_q;
      o_valid_d = 1'b1;
      o_last_d  = (nxt_idx_q == IDX_LAST) && (nxt_ch_q == hi_en);
      if (nxt_idx_q == IDX_LAST) begin
        nxt_idx_d = '0;
        nxt_ch_d  = after_en;
      end else begin
        nxt_idx_d = nxt_idx_q + 1'b1;
      end
    end

    if (i_start) begin
      state_d   = COLLECT;
      en_d      = i_ch_en;
      tcnt_d    = '0;
      tmo_err_d = '0;
      o_valid_d = 1'b0;
      o_last_d  = 1'b0;
      o_done_d  = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      en_q      <= '0;
      tcnt_q    <= '0;
      tmo_err_q <= '0;
      nxt_ch_q  <= '0;
      nxt_idx_q <= '0;
      o_data_q  <= '0;
      o_ch_q    <= '0;
      o_idx_q   <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      tcnt_q    <= tcnt_d;
      tmo_err_q <= tmo_err_d;
      nxt_ch_q  <= nxt_ch_d;
      nxt_idx_q <= nxt_idx_d;
      o_data_q  <= o_data_d;
      o_ch_q    <= o_ch_d;
      o_idx_q   <= o_idx_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      o_done_q  <= o_done_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_ch    = o_ch_q;
  assign o_idx   = o_idx_q;
  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign o_done  = o_done_q;
  assign o_busy  = (state_q != IDLE);
  assign o_err   = ovf | tmo_err_q;

endmodule

// File: tb/tb_uart_resp_collector.sv
// Bench for uart_resp_collector (N=5, BYTES=4, TIMEOUT=1000).
module tb_uart_resp_collector;

  localparam int N       = 5;
  localparam int BYTES   = 4;
  localparam int TIMEOUT = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [N-1:0]  i_ch_en = '0;
  logic [N-1:0]  i_rx_valid = '0;
  logic [8*N-1:0] i_rx_data = '0;
  logic          i_ready = 1'b0;
  logic [7:0]    o_data;
  logic          o_valid;
  logic [2:0]    o_ch;
  logic [1:0]    o_idx;
  logic          o_last;
  logic          o_busy;
  logic [N-1:0]  o_err;
  logic          o_done;

  uart_resp_collector #(.N(N), .BYTES(BYTES), .TIMEOUT(TIMEOUT), .FILL(8'hFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_ch_en    (i_ch_en),
    .i_rx_valid (i_rx_valid),
    .i_rx_data  (i_rx_data),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_ch       (o_ch),
    .o_idx      (o_idx),
    .o_last     (o_last),
    .o_busy     (o_busy),
    .o_err      (o_err),
    .o_done     (o_done)
  );

  // ---------------- clock / cycle counter / monitors ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int first_valid_cyc = -1;
  int done_cnt = 0;
  int done_cyc = -1;
  always @(negedge clk) begin
    if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (o_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [N-1:0] en_m;
  logic [7:0]   mem_m [N][BYTES];
  int           cnt_m [N];
  logic [N-1:0] ovf_m;
  int           full_edge;
  int           start_edge;
  int           plan [N];
  logic [12:0]  exp_q [$];
  logic [N-1:0] exp_err;
  int           exp_first_valid;

  function automatic bit all_full();
    for (int k = 0; k < N; k++)
      if (en_m[k] && cnt_m[k] < BYTES) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_accept(input int k, input logic [7:0] d);
    if (!en_m[k]) return;
    if (full_edge >= 0 && cyc > full_edge + 1) return;
    if (cnt_m[k] < BYTES) begin
      mem_m[k][cnt_m[k]] = d;
      cnt_m[k] = cnt_m[k] + 1;
    end else begin
      ovf_m[k] = 1'b1;
    end
  endtask

  task automatic build_expected();
    bit timed_out;
    logic [7:0] b;
    timed_out = (full_edge < 0);
    exp_err = ovf_m;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      if (timed_out && en_m[k] && cnt_m[k] < BYTES) exp_err[k] = 1'b1;
      if (en_m[k]) begin
        for (int i = 0; i < BYTES; i++) begin
          b = (i < cnt_m[k]) ? mem_m[k][i] : 8'hFF;
          exp_q.push_back({3'(k), 2'(i), b});
        end
      end
    end
    exp_first_valid = timed_out ? (start_edge + TIMEOUT + 1) : (full_edge + 2);
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_cycle(input logic [N-1:0] mask);
    i_start = 1'b1;
    i_ch_en = mask;
    @(posedge clk); #1;
    i_start = 1'b0;
    start_edge = cyc;
    first_valid_cyc = -1;
    done_cnt = 0;
    done_cyc = -1;
    en_m = mask;
    for (int k = 0; k < N; k++) cnt_m[k] = 0;
    ovf_m = '0;
    full_edge = (mask == '0) ? start_edge : -1;
    exp_q.delete();
  endtask

  // mode 0: byte = {k, idx}; mode 1: random; mode 2: like 0 but ch2 sends A0, A1, ...
  task automatic feed(input int mode);
    int sent [N];
    logic [7:0] dv [N];
    bit sv [N];
    bit more;
    int guard;
    for (int k = 0; k < N; k++) sent[k] = 0;
    more = 1'b1;
    guard = 0;
    while (more && guard < 400) begin
      for (int k = 0; k < N; k++) begin
        sv[k] = 1'b0;
        dv[k] = 8'h00;
        if (sent[k] < plan[k] && $urandom_range(0, 1) == 1) begin
          sv[k] = 1'b1;
          if (mode == 1) dv[k] = 8'($urandom_range(0, 255));
          else if (mode == 2 && k == 2) dv[k] = 8'(8'hA0 + sent[k]);
          else dv[k] = 8'(k * 16 + sent[k]);
          i_rx_valid[k] = 1'b1;
          i_rx_data[8*k +: 8] = dv[k];
          sent[k] = sent[k] + 1;
        end
      end
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) if (sv[k]) model_accept(k, dv[k]);
      i_rx_valid = '0;
      if (full_edge < 0 && all_full()) full_edge = cyc;
      more = 1'b0;
      for (int k = 0; k < N; k++) if (sent[k] < plan[k]) more = 1'b1;
      guard++;
    end
  endtask

  // ready_mode 0: ready held high; 1: pattern 1,0,0,1. abort_after > 0 stops after that many handshakes.
  task automatic drain_check(input string name, input int ready_mode, input int abort_after);
    int it, hs, last_hs_edge;
    bit stall_prev, did_hs;
    logic [13:0] prev, cur;
    logic [12:0] got, exp_item;
    it = 0; hs = 0; last_hs_edge = -1; stall_prev = 1'b0; prev = '0;
    while (exp_q.size() > 0 && it < 3000) begin
      i_ready = (ready_mode == 0) ? 1'b1 : ((it % 4 == 0) || (it % 4 == 3));
      @(negedge clk);
      cur = {o_ch, o_idx, o_data, o_last};
      did_hs = 1'b0;
      if (stall_prev) begin
        checks++;
        if (!o_valid || cur !== prev) begin
          errors++;
          $display("FAIL %s stall_hold: got v=%b %h expected v=1 %h", name, o_valid, cur, prev);
        end
      end
      if (o_valid && i_ready) begin
        got = {o_ch, o_idx, o_data};
        exp_item = exp_q.pop_front();
        checks++;
        if (got !== exp_item) begin
          errors++;
          $display("FAIL %s byte%0d: got ch=%0d idx=%0d data=%h expected ch=%0d idx=%0d data=%h",
                   name, hs, got[12:10], got[9:8], got[7:0], exp_item[12:10], exp_item[9:8], exp_item[7:0]);
        end
        checks++;
        if (o_last !== (exp_q.size() == 0)) begin
          errors++;
          $display("FAIL %s last%0d: got %b expected %b", name, hs, o_last, (exp_q.size() == 0));
        end
        hs++;
        did_hs = 1'b1;
      end
      stall_prev = o_valid && !i_ready;
      prev = cur;
      @(posedge clk); #1;
      if (did_hs) last_hs_edge = cyc;
      it++;
      if (abort_after > 0 && hs == abort_after) break;
    end
    i_ready = 1'b0;
    if (abort_after == 0) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL %s drain_budget: got %0d bytes left expected 0", name, exp_q.size());
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (done_cnt != 1 || done_cyc != last_hs_edge) begin
        errors++;
        $display("FAIL %s done: got cnt=%0d at %0d expected cnt=1 at %0d", name, done_cnt, done_cyc, last_hs_edge);
      end
      checks++;
      if (first_valid_cyc != exp_first_valid) begin
        errors++;
        $display("FAIL %s first_valid: got cycle %0d expected %0d", name, first_valid_cyc, exp_first_valid);
      end
      checks++;
      if (o_err !== exp_err) begin
        errors++;
        $display("FAIL %s err: got %b expected %b", name, o_err, exp_err);
      end
      checks++;
      if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s idle: got busy=%b valid=%b expected 0 0", name, o_busy, o_valid);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (o_valid !== 1'b0 || o_last !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 ||
        o_err !== '0 || o_data !== 8'h00 || o_ch !== 3'd0 || o_idx !== 2'd0) begin
      errors++;
      $display("FAIL %s: got v=%b l=%b b=%b d=%b e=%b data=%h ch=%0d idx=%0d expected all 0",
               name, o_valid, o_last, o_busy, o_done, o_err, o_data, o_ch, o_idx);
    end
  endtask

  task automatic set_plan(input int p0, input int p1, input int p2, input int p3, input int p4);
    plan[0] = p0; plan[1] = p1; plan[2] = p2; plan[3] = p3; plan[4] = p4;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst = 1'b0;
    #2 check_all_zero("reset_async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_release");
    @(posedge clk); #1;
  endtask

  task automatic test_all_channels();
    start_cycle(5'b11111);
    set_plan(4, 4, 4, 4, 4);
    feed(0);
    build_expected();
    drain_check("all_channels", 0, 0);
  endtask

  task automatic test_mask();
    start_cycle(5'b10101);
    set_plan(4, 4, 4, 4, 4);
    feed(1);
    build_expected();
    drain_check("mask", 0, 0);
  endtask

  task automatic test_timeout();
    start_cycle(5'b11111);
    set_plan(4, 4, 2, 4, 4);
    feed(2);
    build_expected();
    drain_check("timeout", 0, 0);
  endtask

  task automatic test_overflow();
    start_cycle(5'b11111);
    set_plan(6, 0, 0, 0, 0);
    feed(1);
    set_plan(0, 4, 4, 4, 4);
    feed(1);
    build_expected();
    drain_check("overflow", 0, 0);
  endtask

  task automatic test_stall();
    start_cycle(5'b11111);
    set_plan(4, 4, 4, 4, 4);
    feed(1);
    build_expected();
    drain_check("stall", 1, 0);
  endtask

  task automatic test_mask_zero();
    start_cycle(5'b00000);
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (done_cnt != 1 || done_cyc != start_edge + 2) begin
      errors++;
      $display("FAIL mask_zero done: got cnt=%0d at %0d expected cnt=1 at %0d", done_cnt, done_cyc, start_edge + 2);
    end
    checks++;
    if (first_valid_cyc != -1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mask_zero idle: got first_valid=%0d busy=%b expected -1 0", first_valid_cyc, o_busy);
    end
  endtask

  task automatic test_abort();
    start_cycle(5'b11111);
    set_plan(4, 4, 4, 4, 4);
    feed(1);
    build_expected();
    drain_check("abort_pre", 0, 7);
    start_cycle(5'b01110);
    checks++;
    if (o_valid !== 1'b0 || o_last !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_drop: got v=%b l=%b busy=%b expected 0 0 1", o_valid, o_last, o_busy);
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (done_cnt != 0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got done_cnt=%0d valid=%b expected 0 0", done_cnt, o_valid);
    end
    set_plan(4, 4, 4, 4, 4);
    feed(1);
    build_expected();
    drain_check("abort_post", 0, 0);
  endtask

  task automatic test_async_reset();
    start_cycle(5'b11111);
    set_plan(6, 0, 0, 0, 0);
    feed(1);
    @(negedge clk);
    checks++;
    if (o_err !== 5'b00001 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got err=%b busy=%b expected 00001 1", o_err, o_busy);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1 check_all_zero("async_reset_mid_collect");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    start_cycle(5'b11111);
    set_plan(4, 4, 4, 4, 4);
    feed(0);
    build_expected();
    drain_check("after_reset", 0, 0);
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    for (int r = 0; r < 3; r++) begin
      mask = N'($urandom_range(1, 31));
      start_cycle(mask);
      set_plan($urandom_range(3, 6), $urandom_range(3, 6), $urandom_range(3, 6),
               $urandom_range(3, 6), $urandom_range(3, 6));
      feed(1);
      build_expected();
      drain_check("random", $urandom_range(0, 1), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_channels();
    test_mask();
    test_timeout();
    test_overflow();
    test_stall();
    test_mask_zero();
    test_abort();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_resp_collector.md
Name: uart_resp_collector

Overview:
- Parametrised N-channel collector for LCB response bytes arriving from UART_RX receivers during one orbit request cycle.
- Each channel buffers exactly BYTES bytes, with per-channel enable, overflow detection and timeout fill.
- Once every enabled channel is complete, or the cycle times out, it drains all channels in fixed order 0..N-1 as one valid/ready byte stream to the orbit packer.
- Replaces the per-channel write-address counters, small RAMs and the read-commutator chain.

Parameters:
N, 5, number of UART channels (1..16)
BYTES, 4, bytes expected per channel per cycle (1..32)
TIMEOUT, 4000, clk cycles from i_start to forced drain (>=2)
FILL, 8'hFF, byte substituted for bytes not received

Ports:
clk  in  1  system clock (80 MHz domain)
rst  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse: new request cycle; clears buffers and arms collection
i_ch_en  in  N  channel enable mask, sampled at i_start
i_rx_valid  in  N  per-channel byte strobe from UART_RX (one-cycle pulse)
i_rx_data  in  8*N  per-channel byte; channel k occupies bits [8k+7:8k]
o_data  out  8  drained byte
o_valid  out  1  o_data valid
i_ready  in  1  consumer accepts o_data when o_valid && i_ready
o_ch  out  CHW  channel of o_data; CHW = max(1, clog2(N))
o_idx  out  IDXW  byte index within channel; IDXW = max(1, clog2(BYTES))
o_last  out  1  high with the final byte of the drain
o_busy  out  1  high in COLLECT or DRAIN
o_err  out  N  per channel: timeout-filled or overflowed; valid from drain start until next i_start
o_done  out  1  one-cycle pulse after the last byte handshake

Behaviour:
- Reset (rst=0, async): state IDLE; all counters, buffers, o_err and the latched enable mask = 0; o_valid=0, o_last=0, o_busy=0, o_done=0; o_data=0, o_ch=0, o_idx=0.
- Storage: N x BYTES x 8 register array; per-channel write counter wcnt[k] 0..BYTES; complete[k] = (wcnt[k]==BYTES) or !en[k].
- IDLE: waits for i_start. Any rx strobe is ignored.
- i_start, in any state, has top priority. It:
  - latches i_ch_en;
  - clears wcnt, o_err and the timeout counter;
  - drops o_valid;
  - moves to COLLECT next cycle.
  - Effect: i_start during DRAIN aborts the stream with no o_last and no o_done.
- COLLECT:
  - Write path, for enabled k: i_rx_valid[k] with wcnt[k]<BYTES writes byte at index wcnt[k] and increments wcnt[k].
  - Overflow: a strobe with wcnt[k]==BYTES drops the byte and sets o_err[k].
  - Disabled channels ignore strobes.
  - All channels may write in the same cycle, independently.
  - Timeout counter increments every cycle.
  - Exit to DRAIN when all complete[k] are set (checked on registered counts, one cycle after the last write), or when the counter reaches TIMEOUT-1.
  - On timeout, each enabled channel with wcnt<BYTES sets o_err[k]; its unwritten bytes read as FILL.
  - If completion and timeout occur in the same cycle, completion wins and no err is set.
- DRAIN:
  - Walks enabled channels only, ascending k; within a channel idx runs 0..BYTES-1.
  - o_valid is asserted the cycle after entering DRAIN; o_data/o_ch/o_idx are registered.
  - On handshake, advances to the next byte the following cycle, giving 1 byte/cycle with i_ready held high.
  - o_data/o_ch/o_idx/o_valid are stable while i_ready=0.
  - o_last marks the final byte of the highest enabled channel.
  - After the o_last handshake: o_done pulses and the FSM returns to IDLE.
- Strobes arriving in DRAIN are ignored and do not set err.
- Mask all zero: COLLECT exits after 1 cycle; DRAIN emits nothing; o_done pulses one cycle after entering DRAIN; o_busy drops.
- Latency: last rx strobe to first o_valid = 3 clk.

Decomposition:
- Shared package (orb_pkg): CHW/IDXW clog2 helper function, FILL default constant, and state enum {IDLE, COLLECT, DRAIN}.
- One natural sub-module, uart_chan_buf: per-channel byte store + wcnt + overflow flag, instantiated N times via generate.
- Top level: FSM, timeout counter and drain mux.

Test Plan:
1. N=5, BYTES=4, mask 5'b11111; each channel k receives bytes {k0,k1,k2,k3} (e.g. 8'h10..8'h13 for ch1); i_ready=1 -> 20 bytes in order ch0 idx0..ch4 idx3 on consecutive cycles, o_last on ch4/idx3, o_err=0, one o_done pulse.
2. Mask 5'b10101; ch1/ch3 also receive bytes -> only 12 bytes from ch0, ch2, ch4; o_last on ch4 idx3; o_err=0.
3. ch2 receives only 2 bytes (8'hA0, 8'hA1), TIMEOUT=1000 -> drain starts 1000 cycles after i_start; ch2 bytes are A0, A1, FF, FF; o_err=5'b00100.
4. ch0 receives 6 bytes -> first 4 stored, o_err[0]=1; all other channels normal.
5. i_ready toggles 1,0,0,1 repeatedly during drain -> no byte lost or duplicated; outputs stable while stalled; still 20 handshakes.
6. i_start asserted mid-DRAIN after 7 bytes -> o_valid drops the next cycle, no o_done, fresh COLLECT; asynchronous reset mid-COLLECT -> all outputs 0 immediately, and a subsequent cycle completes correctly.
